// File: rtl/parity_serial_tx.sv
// Serial transmitter for parity-protected words.
// Each frame is start(0), data LSB first, parity, stop(1); every bit is held CLKS_PER_BIT cycles.
module parity_serial_tx #(
    parameter int WIDTH        = 4,
    parameter int CLKS_PER_BIT = 4,
    parameter int ODD_PARITY   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             tx_out,
    output logic             tx_busy,
    output logic             done
);

    // state  | meaning
    // IDLE   | line high, ready for a word
    // START  | start bit (0)
    // DATA   | data bits, LSB first
    // PARITY | parity bit
    // STOP   | stop bit (1), done pulses on exit
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  shift_q;
    logic [WIDTH-1:0]  shift_d;
    logic              par_q;
    logic [CW-1:0]     clk_cnt_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              tx_q;
    logic              ready_q;
    logic              busy_q;
    logic              done_q;
    logic              bit_end;

    assign bit_end = (clk_cnt_q == CLK_LAST);
    assign shift_d = shift_q >> 1;

    // Outputs are computed from the next state so they are plain flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            par_q     <= 1'b0;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q != IDLE) begin
                clk_cnt_q <= bit_end ? '0 : clk_cnt_q + CW'(1);
            end
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        shift_q <= data_in;
                        par_q   <= (ODD_PARITY != 0) ? ~^data_in : ^data_in;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state_q <= DATA;
                        tx_q    <= shift_q[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            state_q   <= PARITY;
                            tx_q      <= par_q;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BW'(1);
                            shift_q   <= shift_d;
                            tx_q      <= shift_d[0];
                        end
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        state_q <= IDLE;
                        tx_q    <= 1'b1;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_out = ready_q;
    assign tx_out    = tx_q;
    assign tx_busy   = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Bench for parity_serial_tx: an even-parity and an odd-parity instance share inputs,
// and each serial line is compared cycle by cycle against a frame built from the word.
module tb_parity_serial_tx;

    localparam int W  = 4;
    localparam int C  = 2;
    localparam int FL = (W + 3) * C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         ready_e, tx_e, busy_e, done_e;
    logic         ready_o, tx_o, busy_o, done_o;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    parity_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .ODD_PARITY(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_e), .tx_out(tx_e), .tx_busy(busy_e), .done(done_e)
    );

    parity_serial_tx #(.WIDTH(W), .CLKS_PER_BIT(C), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .valid_in(valid_in),
        .ready_out(ready_o), .tx_out(tx_o), .tx_busy(busy_o), .done(done_o)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Frame bit k cycles after accept: start, data LSB first, parity, stop.
    function automatic logic ref_bit(input logic [W-1:0] d, input bit odd, input int k);
        int   b;
        logic par;
        b   = k / C;
        par = logic'(($countones(d) % 2) == 1) ^ odd;
        if (b == 0) return 1'b0;
        if (b <= W) return d[b-1];
        if (b == W + 1) return par;
        return 1'b1;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame_cycle(input logic [W-1:0] d, input int k);
        chk($sformatf("tx_even d=%h k=%0d", d, k), tx_e, ref_bit(d, 1'b0, k));
        chk($sformatf("tx_odd d=%h k=%0d", d, k), tx_o, ref_bit(d, 1'b1, k));
        chk("busy_even", busy_e, 1'b1);
        chk("busy_odd", busy_o, 1'b1);
        chk("ready_even", ready_e, 1'b0);
        chk("ready_odd", ready_o, 1'b0);
        chk("done_even", done_e, 1'b0);
        chk("done_odd", done_o, 1'b0);
    endtask

    task automatic check_idle(input string tag, input logic done_exp);
        chk({tag, " tx_even"}, tx_e, 1'b1);
        chk({tag, " tx_odd"}, tx_o, 1'b1);
        chk({tag, " busy_even"}, busy_e, 1'b0);
        chk({tag, " busy_odd"}, busy_o, 1'b0);
        chk({tag, " ready_even"}, ready_e, 1'b1);
        chk({tag, " ready_odd"}, ready_o, 1'b1);
        chk({tag, " done_even"}, done_e, done_exp);
        chk({tag, " done_odd"}, done_o, done_exp);
    endtask

    task automatic start_frame(input logic [W-1:0] d);
        int n;
        n = 0;
        while (!(ready_e && ready_o) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("ready_timeout", ready_e & ready_o, 1'b1);
        valid_in = 1'b1;
        data_in  = d;
    endtask

    // Runs a frame whose accept edge is the next rising edge, ending in the done cycle.
    task automatic run_frame(input logic [W-1:0] d, input bit chain,
                             input logic [W-1:0] nd, input bit inject);
        for (int k = 0; k < FL; k++) begin
            step();
            check_frame_cycle(d, k);
            if (inject && k >= 5 && k < 9) begin
                valid_in = 1'b1;
                data_in  = 4'h3;
            end else begin
                valid_in = 1'b0;
                data_in  = W'($urandom);
            end
        end
        step();
        check_idle("done_cycle", 1'b1);
        if (chain) begin
            valid_in = 1'b1;
            data_in  = nd;
        end
    endtask

    initial begin
        logic [W-1:0] cur, nxt;
        bit           ch;
        int           gap;

        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            check_idle("reset", 1'b0);
            step();
        end
        check_idle("reset_hold", 1'b0);
        rst_n = 1'b1;
        step();
        check_idle("post_reset", 1'b0);

        foreach (cur[i]) cur[i] = 1'b0;
        start_frame(4'b1011);
        run_frame(4'b1011, 1'b0, 4'h0, 1'b0);
        step();
        check_idle("after_1011", 1'b0);

        start_frame(4'b0000);
        run_frame(4'b0000, 1'b0, 4'h0, 1'b0);
        step();
        check_idle("after_0000", 1'b0);
        start_frame(4'b1111);
        run_frame(4'b1111, 1'b0, 4'h0, 1'b0);
        step();
        check_idle("after_1111", 1'b0);

        start_frame(4'h5);
        run_frame(4'h5, 1'b1, 4'hA, 1'b0);
        run_frame(4'hA, 1'b0, 4'h0, 1'b0);
        step();
        check_idle("after_b2b", 1'b0);

        start_frame(4'h9);
        run_frame(4'h9, 1'b0, 4'h0, 1'b1);
        step();
        check_idle("after_ignore", 1'b0);

        start_frame(4'hC);
        for (int k = 0; k <= 3 * C; k++) begin
            step();
            check_frame_cycle(4'hC, k);
            valid_in = 1'b0;
            data_in  = W'($urandom);
        end
        #2 rst_n = 1'b0;
        #1 check_idle("abort_async", 1'b0);
        step();
        check_idle("abort_held", 1'b0);
        rst_n = 1'b1;
        step();
        check_idle("abort_release", 1'b0);
        start_frame(4'h6);
        run_frame(4'h6, 1'b0, 4'h0, 1'b0);
        step();
        check_idle("after_6", 1'b0);

        cur = W'($urandom);
        start_frame(cur);
        for (int i = 0; i < 20; i++) begin
            nxt = W'($urandom);
            ch  = 1'($urandom_range(0, 1));
            run_frame(cur, ch, nxt, 1'b0);
            if (!ch) begin
                gap = $urandom_range(1, 3);
                for (int g = 0; g < gap; g++) begin
                    step();
                    check_idle("rand_gap", 1'b0);
                end
                start_frame(nxt);
            end
            cur = nxt;
        end
        run_frame(cur, 1'b0, 4'h0, 1'b0);
        step();
        check_idle("rand_end", 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
